// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order fetch-to-decode instruction queue with flush (optional bypass: FETCH_QUEUE_BYPASS_EN)
module fetch_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_WIDTH-1:0]        in_pc,
    input  logic [DATA_WIDTH-1:0]        in_inst,
    input  logic                         in_pred_valid,
    input  logic                         in_pred_taken,
    input  logic [ADDR_WIDTH-1:0]        in_pred_target,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDR_WIDTH-1:0]        out_pc,
    output logic [DATA_WIDTH-1:0]        out_inst,
    output logic                         out_pred_valid,
    output logic                         out_pred_taken,
    output logic [ADDR_WIDTH-1:0]        out_pred_target,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_WIDTH-1:0] pc_mem     [DEPTH];
    logic [DATA_WIDTH-1:0] inst_mem   [DEPTH];
    logic                  pvalid_mem [DEPTH];
    logic                  ptaken_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] ptgt_mem   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic empty;
    logic full;
    logic bypass_active;
    logic enq;
    logic deq;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    // Ready depends only on registered occupancy so no combinational path from out_ready.
    assign in_ready = !full;
    assign count    = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_active = empty && !flush;
`else
    assign bypass_active = 1'b0;
`endif

    // A bypassed entry that decode takes immediately never touches storage.
    assign enq = in_valid && in_ready && !flush && !(bypass_active && out_ready);
    assign deq = out_valid && out_ready && !flush && !bypass_active;

    // Head entry (or live input when bypassing) presented to decode, zeroed when not valid.
    always_comb begin
        out_valid       = 1'b0;
        out_pc          = '0;
        out_inst        = '0;
        out_pred_valid  = 1'b0;
        out_pred_taken  = 1'b0;
        out_pred_target = '0;
        if (bypass_active) begin
            out_valid = in_valid;
            if (in_valid) begin
                out_pc          = in_pc;
                out_inst        = in_inst;
                out_pred_valid  = in_pred_valid;
                out_pred_taken  = in_pred_taken;
                out_pred_target = in_pred_target;
            end
        end else if (!empty && !flush) begin
            out_valid       = 1'b1;
            out_pc          = pc_mem[head_q];
            out_inst        = inst_mem[head_q];
            out_pred_valid  = pvalid_mem[head_q];
            out_pred_taken  = ptaken_mem[head_q];
            out_pred_target = ptgt_mem[head_q];
        end
    end

    // Pointer and occupancy next state; flush clears everything and wins over any transfer.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + 1'b1;
            if (deq) head_d = head_q + 1'b1;
            if (enq && !deq)      count_d = count_q + CNT_W'(1);
            else if (deq && !enq) count_d = count_q - CNT_W'(1);
        end
    end

    // Control state registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[tail_q]     <= in_pc;
            inst_mem[tail_q]   <= in_inst;
            pvalid_mem[tail_q] <= in_pred_valid;
            ptaken_mem[tail_q] <= in_pred_taken;
            ptgt_mem[tail_q]   <= in_pred_target;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_pred_valid;
    logic        in_pred_taken;
    logic [31:0] in_pred_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_pred_valid;
    logic        out_pred_taken;
    logic [31:0] out_pred_target;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    fetch_queue #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .in_pred_valid(in_pred_valid), .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_pred_valid(out_pred_valid), .out_pred_taken(out_pred_taken), .out_pred_target(out_pred_target),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic ordy);
        in_valid = v;
        in_pc    = pc;
        in_inst  = inst_of(pc);
        out_ready = ordy;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        in_pred_valid = 1'b0; in_pred_taken = 1'b0; in_pred_target = '0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (out_pc !== 32'h0 || out_inst !== 32'h0) begin n_err++; $display("FAIL reset_payload got pc=%h inst=%h want 0", out_pc, out_inst); end
        rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b1, 32'h100 + 32'(4*i), 1'b0);
        end
        @(negedge clk);
        drive(1'b1, 32'h110, 1'b0);
        #1;
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_count got %0d want 4", count); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_in_ready got %0b want 0", in_ready); end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0);
        #1;
        n_cmp++; if (count !== 3'd4 || out_pc !== 32'h100) begin n_err++; $display("FAIL fill_reject got count=%0d pc=%h want 4/00000100", count, out_pc); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b0, 32'h0, 1'b1);
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4*i) || out_inst !== inst_of(32'h100 + 32'(4*i))) begin
                n_err++; $display("FAIL drain_%0d got v=%0b pc=%h inst=%h want pc=%h", i, out_valid, out_pc, out_inst, 32'h100 + 32'(4*i));
            end
        end
        @(negedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL drain_empty got v=%0b count=%0d want 0/0", out_valid, count); end
        n_cmp++; if (out_pc !== 32'h0 || out_inst !== 32'h0) begin n_err++; $display("FAIL drain_payload got pc=%h inst=%h want 0", out_pc, out_inst); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(1'b1, 32'h200 + 32'(4*k), 1'b1);
            #1;
`ifdef FETCH_QUEUE_BYPASS_EN
            exp_pc = 32'h200 + 32'(4*k);
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc || count !== 3'd0) begin
                n_err++; $display("FAIL b2b_%0d got v=%0b pc=%h count=%0d want 1/%h/0", k, out_valid, out_pc, count, exp_pc);
            end
`else
            exp_pc = 32'h200 + 32'(4*(k-1));
            n_cmp++;
            if (k == 0) begin
                if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_first got v=%0b want 0", out_valid); end
            end else if (out_valid !== 1'b1 || out_pc !== exp_pc || count !== 3'd1) begin
                n_err++; $display("FAIL b2b_%0d got v=%0b pc=%h count=%0d want 1/%h/1", k, out_valid, out_pc, count, exp_pc);
            end
`endif
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1);
        #1;
`ifndef FETCH_QUEUE_BYPASS_EN
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h24C) begin n_err++; $display("FAIL b2b_last got v=%0b pc=%h want 1/0000024c", out_valid, out_pc); end
        @(negedge clk);
        #1;
`endif
        n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end got count=%0d v=%0b want 0/0", count, out_valid); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 32'h2F0 + 32'(4*i), 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0);
        #1;
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL flush_pre_count got %0d want 3", count); end
        @(negedge clk);
        flush = 1'b1;
        drive(1'b1, 32'h300, 1'b1);
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin n_err++; $display("FAIL flush_cycle got v=%0b pc=%h want 0/0", out_valid, out_pc); end
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        #1;
        n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL flush_after got count=%0d v=%0b rdy=%0b want 0/0/1", count, out_valid, in_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_cmp++; if (out_valid !== 1'b0 || out_pc === 32'h300) begin n_err++; $display("FAIL flush_ghost_%0d got v=%0b pc=%h want 0", i, out_valid, out_pc); end
        end
    endtask

    task automatic test_pred();
        @(negedge clk);
        drive(1'b1, 32'h400, 1'b0);
        in_pred_valid = 1'b1; in_pred_taken = 1'b1; in_pred_target = 32'h480;
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1);
        in_pred_valid = 1'b0; in_pred_taken = 1'b0; in_pred_target = '0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 32'h400 || out_inst !== inst_of(32'h400) ||
            out_pred_valid !== 1'b1 || out_pred_taken !== 1'b1 || out_pred_target !== 32'h480) begin
            n_err++; $display("FAIL pred_carry got v=%0b pc=%h pv=%0b pt=%0b tgt=%h want 1/400/1/1/480",
                              out_valid, out_pc, out_pred_valid, out_pred_taken, out_pred_target);
        end
        @(negedge clk);
        #1;
        n_cmp++; if (count !== 3'd0 || out_pred_target !== 32'h0) begin n_err++; $display("FAIL pred_drained got count=%0d tgt=%h want 0/0", count, out_pred_target); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b1, 32'h600 + 32'(4*i), 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0);
        #1;
        n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL arst_pre_count got %0d want 2", count); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL arst_immediate got count=%0d v=%0b rdy=%0b want 0/0/1", count, out_valid, in_ready); end
        @(negedge clk);
        rst = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        @(negedge clk);
        drive(1'b1, 32'h500, 1'b1);
        #1;
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h500) begin n_err++; $display("FAIL bypass_same_cycle got v=%0b pc=%h want 1/500", out_valid, out_pc); end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1);
        #1;
        n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL bypass_count got count=%0d v=%0b want 0/0", count, out_valid); end
`endif
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_flush();
        test_pred();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
